// File: rtl/connect4_pkg.sv
// Shared constants and types for the connect4 referee and its move FIFO.
// The status codes match the engine-facing status word.
package connect4_pkg;

    localparam int COLS = 7;
    localparam int ROWS = 6;

    localparam logic [2:0] ST_OK         = 3'd0;
    localparam logic [2:0] ST_COL_FULL   = 3'd1;
    localparam logic [2:0] ST_WRONG_TURN = 3'd2;
    localparam logic [2:0] ST_WIN        = 3'd3;
    localparam logic [2:0] ST_TIE        = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_RE = 2'd2,
        S_REPORT  = 2'd3
    } ref_state_e;

    typedef struct packed {
        logic       player;
        logic [2:0] col;
    } move_t;

endpackage

// File: rtl/connect4_referee_move_fifo.sv
// Small synchronous FIFO for buffered player moves; head entry is always on dout.
// DEPTH must be a power of two so the pointers wrap naturally.
module move_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    // A full FIFO refuses pushes even when the same cycle pops.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/connect4_referee.sv
// Referee in front of the connect4 engine: buffers moves, rejects out-of-turn
// moves locally, runs one engine op/re exchange per legal move and keeps scores.
module connect4_referee
    import connect4_pkg::*;
#(
    parameter int MV_DEPTH = 4,
    parameter int SCORE_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mv_valid,
    output logic               mv_ready,
    input  logic               mv_player_id,
    input  logic [2:0]         mv_col_id,
    input  logic               c4_op_ready,
    output logic               c4_op_valid,
    output logic               c4_op_player_id,
    output logic [2:0]         c4_op_col_id,
    output logic               c4_re_ready,
    input  logic               c4_re_valid,
    input  logic               c4_re_err,
    input  logic               c4_re_is_finished,
    input  logic               c4_re_winner,
    input  logic               c4_re_tie,
    output logic               st_valid,
    input  logic               st_ready,
    output logic [2:0]         st_code,
    output logic               st_player,
    output logic               turn,
    output logic [SCORE_W-1:0] wins0,
    output logic [SCORE_W-1:0] wins1,
    output logic [SCORE_W-1:0] ties,
    output logic [SCORE_W-1:0] games
);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    ref_state_e         r_state, w_state_nxt;
    move_t              r_mv, w_mv_nxt;
    logic               r_op_valid, w_op_valid_nxt;
    logic               r_re_ready, w_re_ready_nxt;
    logic               r_st_valid, w_st_valid_nxt;
    logic [2:0]         r_st_code, w_st_code_nxt;
    logic               r_st_player, w_st_player_nxt;
    logic               r_turn, w_turn_nxt;
    logic               r_first, w_first_nxt;
    logic [SCORE_W-1:0] r_wins0, w_wins0_nxt;
    logic [SCORE_W-1:0] r_wins1, w_wins1_nxt;
    logic [SCORE_W-1:0] r_ties, w_ties_nxt;
    logic [SCORE_W-1:0] r_games, w_games_nxt;

    logic  w_full;
    logic  w_empty;
    logic  w_pop;
    move_t w_head;

    move_fifo #(
        .WIDTH ($bits(move_t)),
        .DEPTH (MV_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (mv_valid),
        .din   ({mv_player_id, mv_col_id}),
        .pop   (w_pop),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_head)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_mv_nxt        = r_mv;
        w_op_valid_nxt  = r_op_valid;
        w_re_ready_nxt  = r_re_ready;
        w_st_valid_nxt  = r_st_valid;
        w_st_code_nxt   = r_st_code;
        w_st_player_nxt = r_st_player;
        w_turn_nxt      = r_turn;
        w_first_nxt     = r_first;
        w_wins0_nxt     = r_wins0;
        w_wins1_nxt     = r_wins1;
        w_ties_nxt      = r_ties;
        w_games_nxt     = r_games;
        w_pop           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop    = 1'b1;
                    w_mv_nxt = w_head;
                    if (w_head.player == r_turn) begin
                        w_op_valid_nxt = 1'b1;
                        w_state_nxt    = S_ISSUE;
                    end else begin
                        w_st_valid_nxt  = 1'b1;
                        w_st_code_nxt   = ST_WRONG_TURN;
                        w_st_player_nxt = w_head.player;
                        w_state_nxt     = S_REPORT;
                    end
                end
            end
            S_ISSUE: begin
                if (r_op_valid && c4_op_ready) begin
                    w_op_valid_nxt = 1'b0;
                    w_re_ready_nxt = 1'b1;
                    w_state_nxt    = S_WAIT_RE;
                end
            end
            S_WAIT_RE: begin
                if (r_re_ready && c4_re_valid) begin
                    w_re_ready_nxt  = 1'b0;
                    w_st_valid_nxt  = 1'b1;
                    w_st_player_nxt = r_mv.player;
                    w_state_nxt     = S_REPORT;
                    if (c4_re_err) begin
                        // Turn is kept so the same player retries another column.
                        w_st_code_nxt = ST_COL_FULL;
                    end else if (c4_re_is_finished) begin
                        w_first_nxt = ~r_first;
                        w_turn_nxt  = ~r_first;
                        w_games_nxt = sat_inc(r_games);
                        if (c4_re_tie) begin
                            w_st_code_nxt = ST_TIE;
                            w_ties_nxt    = sat_inc(r_ties);
                        end else begin
                            w_st_code_nxt = ST_WIN;
                            if (c4_re_winner) w_wins1_nxt = sat_inc(r_wins1);
                            else              w_wins0_nxt = sat_inc(r_wins0);
                        end
                    end else begin
                        w_st_code_nxt = ST_OK;
                        w_turn_nxt    = ~r_turn;
                    end
                end
            end
            S_REPORT: begin
                if (r_st_valid && st_ready) begin
                    w_st_valid_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mv        <= '0;
            r_op_valid  <= 1'b0;
            r_re_ready  <= 1'b0;
            r_st_valid  <= 1'b0;
            r_st_code   <= ST_OK;
            r_st_player <= 1'b0;
            r_turn      <= 1'b0;
            r_first     <= 1'b0;
            r_wins0     <= '0;
            r_wins1     <= '0;
            r_ties      <= '0;
            r_games     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mv        <= w_mv_nxt;
            r_op_valid  <= w_op_valid_nxt;
            r_re_ready  <= w_re_ready_nxt;
            r_st_valid  <= w_st_valid_nxt;
            r_st_code   <= w_st_code_nxt;
            r_st_player <= w_st_player_nxt;
            r_turn      <= w_turn_nxt;
            r_first     <= w_first_nxt;
            r_wins0     <= w_wins0_nxt;
            r_wins1     <= w_wins1_nxt;
            r_ties      <= w_ties_nxt;
            r_games     <= w_games_nxt;
        end
    end

    assign mv_ready        = ~w_full;
    assign c4_op_valid     = r_op_valid;
    assign c4_op_player_id = r_mv.player;
    assign c4_op_col_id    = r_mv.col;
    assign c4_re_ready     = r_re_ready;
    assign st_valid        = r_st_valid;
    assign st_code         = r_st_code;
    assign st_player       = r_st_player;
    assign turn            = r_turn;
    assign wins0           = r_wins0;
    assign wins1           = r_wins1;
    assign ties            = r_ties;
    assign games           = r_games;

endmodule

// File: tb/tb_connect4_referee.sv
// Bench for connect4_referee: scripted engine responder plus a scoreboard of
// expected status words built from a reference model when each move is pushed.
module tb_connect4_referee;
    import connect4_pkg::*;

    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mv_valid, mv_ready, mv_player_id;
    logic [2:0]    mv_col_id;
    logic          c4_op_ready, c4_op_valid, c4_op_player_id;
    logic [2:0]    c4_op_col_id;
    logic          c4_re_ready, c4_re_valid, c4_re_err, c4_re_is_finished, c4_re_winner, c4_re_tie;
    logic          st_valid, st_ready, st_player, turn;
    logic [2:0]    st_code;
    logic [SW-1:0] wins0, wins1, ties, games;

    always #5 clk = ~clk;

    connect4_referee #(.MV_DEPTH(4), .SCORE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_player_id(mv_player_id), .mv_col_id(mv_col_id),
        .c4_op_ready(c4_op_ready), .c4_op_valid(c4_op_valid),
        .c4_op_player_id(c4_op_player_id), .c4_op_col_id(c4_op_col_id),
        .c4_re_ready(c4_re_ready), .c4_re_valid(c4_re_valid), .c4_re_err(c4_re_err),
        .c4_re_is_finished(c4_re_is_finished), .c4_re_winner(c4_re_winner), .c4_re_tie(c4_re_tie),
        .st_valid(st_valid), .st_ready(st_ready), .st_code(st_code), .st_player(st_player),
        .turn(turn), .wins0(wins0), .wins1(wins1), .ties(ties), .games(games)
    );

    // kind: 0 OK, 1 column full, 2 win for the mover, 3 tie
    typedef struct { logic p; logic [2:0] c; int kind; } eng_t;
    typedef struct { logic [2:0] code; logic p; logic turn; logic [SW-1:0] w0, w1, t, g; } st_t;

    eng_t eq[$];
    st_t  sq[$];
    int   n_vec = 0, n_err = 0, n_st = 0, n_model = 0;
    bit   st_hold = 1'b0;
    logic m_turn, m_first;
    logic [SW-1:0] m_w0, m_w1, m_t, m_g;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [SW-1:0] sinc(input logic [SW-1:0] v);
        return (v == {SW{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic void model_reset();
        m_turn = 1'b0; m_first = 1'b0;
        m_w0 = '0; m_w1 = '0; m_t = '0; m_g = '0;
        eq.delete(); sq.delete();
        n_st = 0; n_model = 0;
    endfunction

    function automatic void model_move(input logic p, input logic [2:0] c, input int kind);
        st_t  s;
        eng_t e;
        s.p = p;
        n_model++;
        if (p != m_turn) begin
            s.code = ST_WRONG_TURN;
        end else begin
            e.p = p; e.c = c; e.kind = kind;
            eq.push_back(e);
            if (kind == 0) begin
                s.code = ST_OK;
                m_turn = ~m_turn;
            end else if (kind == 1) begin
                s.code = ST_COL_FULL;
            end else begin
                m_first = ~m_first;
                m_turn  = m_first;
                m_g     = sinc(m_g);
                if (kind == 3) begin
                    s.code = ST_TIE;
                    m_t    = sinc(m_t);
                end else begin
                    s.code = ST_WIN;
                    if (p) m_w1 = sinc(m_w1);
                    else   m_w0 = sinc(m_w0);
                end
            end
        end
        s.turn = m_turn; s.w0 = m_w0; s.w1 = m_w1; s.t = m_t; s.g = m_g;
        sq.push_back(s);
    endfunction

    // Called on a negedge; returns on the negedge after the push is accepted.
    task automatic push_move(input logic p, input logic [2:0] c, input int kind);
        int n = 0;
        model_move(p, c, kind);
        mv_valid = 1'b1; mv_player_id = p; mv_col_id = c;
        while (!mv_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("push_timeout", mv_ready, 1'b1);
        @(negedge clk);
        mv_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sq.size() != 0 || eq.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_op_valid"}, c4_op_valid, 1'b0);
        chk({tag, "_re_ready"}, c4_re_ready, 1'b0);
        chk({tag, "_st_valid"}, st_valid, 1'b0);
        chk({tag, "_st_code"}, st_code, 3'd0);
        chk({tag, "_st_player"}, st_player, 1'b0);
        chk({tag, "_turn"}, turn, 1'b0);
        chk({tag, "_mv_ready"}, mv_ready, 1'b1);
        chk({tag, "_counters"}, {wins0, wins1, ties, games}, 32'd0);
    endtask

    // Engine model: random op_ready and re_valid delays, scripted responses.
    initial begin
        eng_t e;
        int   d;
        c4_op_ready = 1'b0; c4_re_valid = 1'b0; c4_re_err = 1'b0;
        c4_re_is_finished = 1'b0; c4_re_winner = 1'b0; c4_re_tie = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && c4_op_valid) begin
                if (eq.size() == 0) begin
                    chk("op_unexpected", c4_op_valid, 1'b0);
                end else begin
                    e = eq.pop_front();
                    chk("op_player", c4_op_player_id, e.p);
                    chk("op_col", c4_op_col_id, e.c);
                    d = $urandom_range(0, 2);
                    repeat (d) begin
                        @(negedge clk);
                        chk("op_hold", {c4_op_valid, c4_op_player_id, c4_op_col_id}, {1'b1, e.p, e.c});
                    end
                    c4_op_ready = 1'b1;
                    @(negedge clk);
                    c4_op_ready = 1'b0;
                    chk("op_drop", c4_op_valid, 1'b0);
                    chk("re_ready", c4_re_ready, 1'b1);
                    d = $urandom_range(0, 2);
                    repeat (d) @(negedge clk);
                    c4_re_valid       = 1'b1;
                    c4_re_err         = (e.kind == 1);
                    c4_re_is_finished = (e.kind >= 2);
                    c4_re_tie         = (e.kind == 3);
                    c4_re_winner      = e.p;
                    @(negedge clk);
                    c4_re_valid = 1'b0; c4_re_err = 1'b0; c4_re_is_finished = 1'b0;
                    c4_re_tie = 1'b0; c4_re_winner = 1'b0;
                    chk("st_latency", st_valid, 1'b1);
                    chk("re_drop", c4_re_ready, 1'b0);
                end
            end
        end
    end

    // Status consumer: compares each status word as it is accepted.
    initial begin
        st_t s;
        st_ready = 1'b0;
        forever begin
            @(negedge clk);
            st_ready = !st_hold && ($urandom_range(0, 3) != 0);
            if (rst_n && st_valid && st_ready) begin
                if (sq.size() == 0) begin
                    chk("st_unexpected", st_valid, 1'b0);
                end else begin
                    s = sq.pop_front();
                    n_st++;
                    chk("st_code", st_code, s.code);
                    chk("st_player", st_player, s.p);
                    chk("turn", turn, s.turn);
                    chk("wins", {wins0, wins1}, {s.w0, s.w1});
                    chk("ties_games", {ties, games}, {s.t, s.g});
                end
            end
        end
    end

    initial begin
        mv_valid = 1'b0; mv_player_id = 1'b0; mv_col_id = 3'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reset_chk("rst");

        // First move latency: op_valid two cycles after the push edge.
        model_move(1'b0, 3'd3, 0);
        mv_valid = 1'b1; mv_player_id = 1'b0; mv_col_id = 3'd3;
        @(negedge clk);
        mv_valid = 1'b0;
        chk("lat_t1", c4_op_valid, 1'b0);
        @(negedge clk);
        chk("lat_t2", c4_op_valid, 1'b1);
        drain();
        chk("ok_turn", turn, 1'b1);

        // Out-of-turn move: status one cycle after pop, no engine op.
        model_move(1'b0, 3'd2, 0);
        mv_valid = 1'b1; mv_player_id = 1'b0; mv_col_id = 3'd2;
        @(negedge clk);
        mv_valid = 1'b0;
        chk("wt_t1", st_valid, 1'b0);
        @(negedge clk);
        chk("wt_t2_st", st_valid, 1'b1);
        chk("wt_t2_op", c4_op_valid, 1'b0);
        drain();
        chk("wt_turn", turn, 1'b1);

        // Column full keeps the turn; retry accepted.
        push_move(1'b1, 3'd5, 1);
        push_move(1'b1, 3'd4, 0);
        drain();

        // Vertical win for player 0, columns 0 vs 1.
        for (int i = 0; i < 3; i++) begin
            push_move(1'b0, 3'd0, 0);
            push_move(1'b1, 3'd1, 0);
        end
        push_move(1'b0, 3'd0, 2);
        drain();
        chk("win_wins0", wins0, 8'd1);
        chk("win_games", games, 8'd1);
        chk("win_turn", turn, 1'b1);

        // Tie, then column 7 passes straight through.
        push_move(1'b1, 3'd6, 3);
        push_move(1'b0, 3'd7, 0);
        drain();
        chk("tie_ties", ties, 8'd1);

        // Back-pressure on status fills the FIFO without losing moves.
        st_hold = 1'b1;
        for (int i = 0; i < 5; i++) push_move(m_turn, 3'(i), 0);
        chk("fifo_full", mv_ready, 1'b0);
        fork
            push_move(m_turn, 3'd6, 0);
        join_none
        repeat (4) @(negedge clk);
        chk("fifo_refuse", mv_ready, 1'b0);
        st_hold = 1'b0;
        drain();
        chk("no_loss", n_st, n_model);

        // Saturation of the game counter.
        for (int i = 0; i < 258; i++) push_move(m_turn, 3'd3, 2);
        drain();
        chk("games_sat", games, 8'hFF);

        // Reset in the middle of a pending status with a move queued.
        st_hold = 1'b1;
        push_move(m_turn, 3'd2, 0);
        push_move(m_turn, 3'd2, 0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        st_hold = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        reset_chk("midrst");
        push_move(1'b0, 3'd1, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/connect4_referee.md
# connect4_referee

Upstream controller for the `connect4` engine. It buffers incoming player moves in a small FIFO and enforces turn order locally, rejecting out-of-turn moves without touching the engine. It issues legal moves over the engine's op handshake, consumes the re handshake, and reports one status word per move. It also keeps saturating win/tie/game counters and alternates the starting player between games.

## Interface
- `MV_DEPTH`, default 4: move FIFO depth; power of two, ≥2.
- `SCORE_W`, default 8: width of each score/game counter.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mv_valid` input 1: move offered.
- `mv_ready` output 1: FIFO not full.
- `mv_player_id` input 1: player issuing the move.
- `mv_col_id` input 3: column 0..6.
- `c4_op_ready` input 1: engine op_ready.
- `c4_op_valid` output 1: engine op_valid.
- `c4_op_player_id` output 1: engine op_player_id.
- `c4_op_col_id` output 3: engine op_col_id.
- `c4_re_ready` output 1: engine re_ready.
- `c4_re_valid` input 1: engine re_valid.
- `c4_re_err` input 1: engine re_err.
- `c4_re_is_finished` input 1: engine re_is_finished.
- `c4_re_winner` input 1: engine re_winner.
- `c4_re_tie` input 1: engine re_tie.
- `st_valid` output 1: status word valid.
- `st_ready` input 1: status consumer ready.
- `st_code` output 3: 0 OK, 1 COL_FULL, 2 WRONG_TURN, 3 WIN, 4 TIE.
- `st_player` output 1: player of the reported move.
- `turn` output 1: player expected to move next.
- `wins0`, `wins1`, `ties`, `games` output SCORE_W each: saturating counters.

## Operation
- Handshake rule: a transfer occurs on a cycle where valid & ready are both high.
- FIFO:
  - push on `mv_valid & mv_ready`; pop only in S_IDLE.
  - `mv_ready = ~full`, driven from the registered count.
  - When full, a push is refused even on a pop cycle.
  - Pointers wrap modulo MV_DEPTH.
- States:
  - **S_IDLE**: if FIFO non-empty, pop the head into the move register.
    - If the move's player equals `turn`: go to S_ISSUE.
    - Otherwise: `st_code`=2 and go to S_REPORT.
  - **S_ISSUE**:
    - `c4_op_valid`=1 with the registered player/col, held stable until `c4_op_ready`.
    - On fire: `c4_op_valid`=0, `c4_re_ready`=1, go to S_WAIT_RE.
  - **S_WAIT_RE**: on `c4_re_valid` fire, `c4_re_ready`=0, then:
    - err → code 1; `turn` unchanged, so the same player retries.
    - finished & tie → code 4; `ties`++, `games`++.
    - finished & ~tie → code 3; increment `wins[c4_re_winner]`, `games`++.
    - else → code 0; `turn` toggles.
    - On finish: `first` toggles and `turn` ← new `first`.
    - Then go to S_REPORT.
  - **S_REPORT**: `st_valid`=1 until `st_ready`, then return to S_IDLE.
- Counters saturate at 2^SCORE_W−1 and never wrap.
- `st_player` is the player of the reported move.
- Column range is not checked here; columns 7 are passed to the engine unchanged.

## Timing
- All outputs are registered, except `mv_ready`, which is derived from the count register.
- Reset values:
  - all valids and `c4_re_ready` = 0
  - `st_code` = 0, `st_player` = 0
  - `turn` = 0, `first` = 0
  - all counters 0, FIFO empty (so `mv_ready` = 1)
  - state S_IDLE
- Latency, push into an empty FIFO at cycle t:
  - entry visible at t+1; popped in S_IDLE at t+1.
  - `c4_op_valid` high at t+2.
- Latency, `c4_re_valid` fire at cycle u: `st_valid` high at u+1.
- A WRONG_TURN move reaches `st_valid` one cycle after its pop and generates no engine transaction.
- At most one engine transaction is outstanding, and there is no pop while a status word is pending.
- Pushes continue in every state.
- Reset mid-operation: everything returns to reset values. The engine shares `rst_n`, so both sides restart consistently.

## Structure
- `connect4_pkg` holds:
  - status code constants (ST_OK, ST_COL_FULL, ST_WRONG_TURN, ST_WIN, ST_TIE);
  - referee state encodings;
  - board constants (COLS=7, ROWS=6).
- Sub-module `move_fifo` (params WIDTH=4, DEPTH):
  - synchronous push/pop;
  - outputs `full`, `empty`, `dout` = head entry.
- Top level holds the FSM, turn logic and counters in the usual `_nxt` combinational block plus a single sequential block.

## Test plan
- After reset, push (p0,c3): `c4_op_valid` rises at t+2 with player 0/col 3. Engine returns OK, giving `st_code`=0, `st_player`=0 and `turn`=1.
- Push (p0,c2) while `turn`=1: no `c4_op_valid`; status `st_code`=2, `turn` stays 1, counters unchanged.
- Engine returns err (full column) for (p1,c5): `st_code`=1, `turn` stays 1; the next (p1,c4) is accepted.
- Play p0 columns 0,0,0,0 interleaved with p1 column 1, with a real `connect4` instance: the fourth p0 move gives `st_code`=3, `wins0`=1, `games`=1, and next `turn`=1.
- Hold `st_ready`=0 and push 5 moves with MV_DEPTH=4: the FIFO fills and `mv_ready`=0; no moves are lost once `st_ready` releases.
- Force `games` to 255 with SCORE_W=8, then finish a game: `games` stays at 255.
